ram_n: RTL



---
 rtl/ram_n.sv | 104 ++++++++++
 1 files changed

// File: rtl/ram_n.sv
// Parametrised Hack-style RAM: combinational read, load-strobed synchronous write,
// and a sequenced clear-all sweep reporting busy/done.
module ram_n #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 clr,
  output logic [WIDTH-1:0]     out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PTR_MAX = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic [WIDTH-1:0]     mem [DEPTH];

  // State register and sweep bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and write-port selection; clr wins over load in IDLE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = in;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end else if (load) begin
          wr_en = 1'b1;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = '0;
        if (ptr_q == PTR_MAX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_BITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Per-word decode so an unknown address cannot disturb unrelated words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_addr == ADDR_BITS'(i))) mem[i] <= wr_data;
      end
    end
  end

  assign out  = mem[address];
  assign busy = busy_q;
  assign done = done_q;

endmodule
